// File: rtl/display7_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | Module      : display7_pkg                                              |
// | Description : Shared widths, vector bit positions and scan FSM states   |
// |               for the display7 decoder scan controller.                 |
// | Revision    : 1.0 - initial release                                     |
// +-------------------------------------------------------------------------+
package display7_pkg;

   localparam int IN_W  = 4;
   localparam int OUT_W = 64;

   // Position of each decoder input inside a 4-bit vector
   localparam int X1_B = 0;
   localparam int X3_B = 1;
   localparam int X5_B = 2;
   localparam int X7_B = 3;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      DRIVE   = 3'd1,
      CAPTURE = 3'd2,
      EMIT    = 3'd3,
      NEXT    = 3'd4,
      FINISH  = 3'd5
   } scan_state_t;

endpackage
`default_nettype wire

// File: rtl/display7_onehot_chk.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | Module      : display7_onehot_chk                                       |
// | Description : Flags an all-zero decoder word and a word with more than  |
// |               one bit set.                                              |
// | Revision    : 1.0 - initial release                                     |
// +-------------------------------------------------------------------------+
module display7_onehot_chk
   import display7_pkg::*;
(
   input  logic [OUT_W-1:0] in_y,
   output logic             zero,
   output logic             multi
);

   // x & (x-1) clears the lowest set bit; anything left means two or more bits
   assign zero  = ~|in_y;
   assign multi = |(in_y & (in_y - OUT_W'(1)));

endmodule
`default_nettype wire

// File: rtl/display7_scan_ctrl.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | Module      : display7_scan_ctrl                                        |
// | Description : Drives the display7 decoder with one vector or a 0..15    |
// |               sweep, captures each settled output and streams results.  |
// | Revision    : 1.0 - initial release                                     |
// +-------------------------------------------------------------------------+
module display7_scan_ctrl
   import display7_pkg::*;
#(
   parameter int DWELL     = 2,
   parameter bit SKIP_ZERO = 1'b1
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sweep,
   input  logic [IN_W-1:0]  vec_in,
   output logic [IN_W-1:0]  dec_x,
   input  logic [OUT_W-1:0] dec_y,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [IN_W-1:0]  res_vec,
   output logic [OUT_W-1:0] res_y,
   output logic [OUT_W-1:0] hit_mask,
   output logic             multi_hot,
   output logic             busy,
   output logic             done
);

   localparam int              CNT_W        = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [CNT_W-1:0] C_DWELL_LAST = CNT_W'(DWELL - 1);

   scan_state_t      state_q,   state_d;
   logic [IN_W-1:0]  vec_q,     vec_d;
   logic [CNT_W-1:0] cnt_q,     cnt_d;
   logic             sweep_q,   sweep_d;
   logic [OUT_W-1:0] res_y_q,   res_y_d;
   logic [IN_W-1:0]  res_vec_q, res_vec_d;
   logic [OUT_W-1:0] hit_q,     hit_d;
   logic             multi_q,   multi_d;

   logic             y_zero;
   logic             y_multi;

   display7_onehot_chk u_onehot_chk (
      .in_y  (dec_y),
      .zero  (y_zero),
      .multi (y_multi)
   );

   // Next-state, datapath updates and state-decoded outputs
   always_comb begin
      state_d   = state_q;
      vec_d     = vec_q;
      cnt_d     = cnt_q;
      sweep_d   = sweep_q;
      res_y_d   = res_y_q;
      res_vec_d = res_vec_q;
      hit_d     = hit_q;
      multi_d   = multi_q;
      res_valid = 1'b0;
      busy      = 1'b1;
      done      = 1'b0;

      case (state_q)
         IDLE: begin
            busy = 1'b0;
            if (start) begin
               sweep_d = sweep;
               vec_d   = sweep ? '0 : vec_in;
               hit_d   = '0;
               multi_d = 1'b0;
               cnt_d   = '0;
               state_d = DRIVE;
            end
         end
         DRIVE: begin
            if (cnt_q == C_DWELL_LAST) begin
               cnt_d   = '0;
               state_d = CAPTURE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         CAPTURE: begin
            res_y_d   = dec_y;
            res_vec_d = vec_q;
            hit_d     = hit_q | dec_y;
            multi_d   = multi_q | y_multi;
            state_d   = (SKIP_ZERO && y_zero) ? NEXT : EMIT;
         end
         EMIT: begin
            res_valid = 1'b1;
            if (res_ready) begin
               state_d = NEXT;
            end
         end
         NEXT: begin
            // A sweep ends at the top vector rather than wrapping to 0
            if (!sweep_q || (vec_q == {IN_W{1'b1}})) begin
               state_d = FINISH;
            end else begin
               vec_d   = vec_q + IN_W'(1);
               state_d = DRIVE;
            end
         end
         FINISH: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         vec_q     <= '0;
         cnt_q     <= '0;
         sweep_q   <= 1'b0;
         res_y_q   <= '0;
         res_vec_q <= '0;
         hit_q     <= '0;
         multi_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         vec_q     <= vec_d;
         cnt_q     <= cnt_d;
         sweep_q   <= sweep_d;
         res_y_q   <= res_y_d;
         res_vec_q <= res_vec_d;
         hit_q     <= hit_d;
         multi_q   <= multi_d;
      end
   end

   assign dec_x     = {vec_q[X7_B], vec_q[X5_B], vec_q[X3_B], vec_q[X1_B]};
   assign res_y     = res_y_q;
   assign res_vec   = res_vec_q;
   assign hit_mask  = hit_q;
   assign multi_hot = multi_q;

endmodule
`default_nettype wire

// File: tb/tb_display7_scan_ctrl.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | Module      : tb_display7_scan_ctrl                                     |
// | Description : Self-checking bench for display7_scan_ctrl. Two instances |
// |               (skip-zero with DWELL=2, emit-all with DWELL=3) share the |
// |               control inputs; each sees its own decoder lookup table.  |
// | Revision    : 1.0 - initial release                                     |
// +-------------------------------------------------------------------------+
module tb_display7_scan_ctrl;

   typedef struct {
      logic [3:0]  vec;
      logic [63:0] y;
   } res_t;

   typedef struct {
      bit          sw;
      logic [3:0]  vec;
      int          ready_mode;   // 0 always ready, 1 stall 10 at first result, 2 random
      int          spur;         // cycle of a stray start pulse, -1 for none
      int          exp_n;
      logic [63:0] exp_hit;
      bit          exp_multi;
      int          exp_done;     // -1 when timing is not checked
      int          exp_n_b;
   } vec_t;

   localparam logic [63:0] C_Y0 = 64'h2000_4000_0000_0000;   // bits 46 and 61
   localparam logic [63:0] C_Y7 = 64'h0000_0000_0000_0008;   // bit 3

   logic        clk = 1'b0;
   logic        rst, start, sweep, res_ready;
   logic [3:0]  vec_in;
   logic [63:0] tab [16];

   logic [3:0]  dx_a, dx_b, rvec_a, rvec_b;
   logic [63:0] dy_a, dy_b, ry_a, ry_b, hm_a, hm_b;
   logic        rv_a, rv_b, mh_a, mh_b, bz_a, bz_b, dn_a, dn_b;

   logic [3:0]  dx [2];
   logic [3:0]  rvec [2];
   logic [63:0] ry [2];
   logic [63:0] hm [2];
   logic        rv [2];
   logic        mh [2];
   logic        bz [2];
   logic        dn [2];

   int tests = 0;
   int fails = 0;

   res_t        exp_r [2][16];
   res_t        got_r [2][16];
   int          exp_n [2];
   int          got_n [2];
   logic [63:0] exp_hit [2];
   bit          exp_multi [2];
   int          exp_cyc [2];
   int          done_cnt [2];
   int          done_t [2];

   vec_t        tbl [6];

   always #5 clk = ~clk;

   // Behavioural decoder stand-in: table lookup on the driven vector
   assign dy_a = tab[dx_a];
   assign dy_b = tab[dx_b];

   assign dx[0] = dx_a;   assign dx[1] = dx_b;
   assign rvec[0] = rvec_a; assign rvec[1] = rvec_b;
   assign ry[0] = ry_a;   assign ry[1] = ry_b;
   assign hm[0] = hm_a;   assign hm[1] = hm_b;
   assign rv[0] = rv_a;   assign rv[1] = rv_b;
   assign mh[0] = mh_a;   assign mh[1] = mh_b;
   assign bz[0] = bz_a;   assign bz[1] = bz_b;
   assign dn[0] = dn_a;   assign dn[1] = dn_b;

   display7_scan_ctrl #(.DWELL(2), .SKIP_ZERO(1'b1)) u_dut_a (
      .clk(clk), .rst(rst), .start(start), .sweep(sweep), .vec_in(vec_in),
      .dec_x(dx_a), .dec_y(dy_a), .res_valid(rv_a), .res_ready(res_ready),
      .res_vec(rvec_a), .res_y(ry_a), .hit_mask(hm_a), .multi_hot(mh_a),
      .busy(bz_a), .done(dn_a)
   );

   display7_scan_ctrl #(.DWELL(3), .SKIP_ZERO(1'b0)) u_dut_b (
      .clk(clk), .rst(rst), .start(start), .sweep(sweep), .vec_in(vec_in),
      .dec_x(dx_b), .dec_y(dy_b), .res_valid(rv_b), .res_ready(res_ready),
      .res_vec(rvec_b), .res_y(ry_b), .hit_mask(hm_b), .multi_hot(mh_b),
      .busy(bz_b), .done(dn_b)
   );

   function automatic int dw_of(input int d);
      return (d == 0) ? 2 : 3;
   endfunction

   function automatic bit skip_of(input int d);
      return (d == 0);
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Expected result list, masks and run length straight from the scan rules
   task automatic model(input int d, input bit sw, input logic [3:0] v);
      int          lo, hi;
      logic [63:0] y;
      bit          emit;
      lo = sw ? 0 : int'(v);
      hi = sw ? 15 : int'(v);
      exp_n[d]     = 0;
      exp_hit[d]   = '0;
      exp_multi[d] = 1'b0;
      exp_cyc[d]   = 0;
      for (int i = lo; i <= hi; i++) begin
         y = tab[i];
         exp_hit[d] |= y;
         if ($countones(y) > 1) exp_multi[d] = 1'b1;
         emit = !(skip_of(d) && (y == 64'd0));
         if (emit) begin
            exp_r[d][exp_n[d]].vec = 4'(i);
            exp_r[d][exp_n[d]].y   = y;
            exp_n[d]++;
         end
         exp_cyc[d] += dw_of(d) + 2 + (emit ? 1 : 0);
      end
   endtask

   task automatic check_reset(input string tag);
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("%s dut%0d dec_x", tag, d), 64'(dx[d]), 64'd0);
         chk($sformatf("%s dut%0d res_vec", tag, d), 64'(rvec[d]), 64'd0);
         chk($sformatf("%s dut%0d res_y", tag, d), ry[d], 64'd0);
         chk($sformatf("%s dut%0d hit_mask", tag, d), hm[d], 64'd0);
         chk($sformatf("%s dut%0d res_valid", tag, d), 64'(rv[d]), 64'd0);
         chk($sformatf("%s dut%0d multi_hot", tag, d), 64'(mh[d]), 64'd0);
         chk($sformatf("%s dut%0d busy", tag, d), 64'(bz[d]), 64'd0);
         chk($sformatf("%s dut%0d done", tag, d), 64'(dn[d]), 64'd0);
      end
   endtask

   // One operation on both instances, collected and compared against the model
   task automatic run_scan(input bit sw, input logic [3:0] v, input int rmode,
                           input int spur, input string tag);
      bit          pv [2];
      logic [63:0] py [2];
      logic [3:0]  pvec [2];
      logic [3:0]  px [2];
      int          stall;
      bit          armed;
      int          lim;
      model(0, sw, v);
      model(1, sw, v);
      for (int d = 0; d < 2; d++) begin
         got_n[d] = 0; done_cnt[d] = 0; done_t[d] = -1; pv[d] = 1'b0;
      end
      stall = 0;
      armed = (rmode == 1);
      @(negedge clk);
      start = 1'b1; sweep = sw; vec_in = v; res_ready = 1'b1;
      @(posedge clk);
      for (int t = 0; t < 3000 && !(done_cnt[0] > 0 && done_cnt[1] > 0); t++) begin
         @(negedge clk);
         start = 1'b0;
         if (t == spur) begin
            start  = 1'b1;
            sweep  = 1'($urandom_range(0, 1));
            vec_in = 4'($urandom_range(0, 15));
         end
         case (rmode)
            0: res_ready = 1'b1;
            1: begin
               if (armed && (rv[0] || rv[1])) begin
                  armed = 1'b0;
                  stall = 10;
               end
               if (stall > 0) begin
                  res_ready = 1'b0;
                  stall--;
               end else begin
                  res_ready = 1'b1;
               end
            end
            default: res_ready = 1'($urandom_range(0, 1));
         endcase
         for (int d = 0; d < 2; d++) begin
            if (pv[d]) begin
               chk($sformatf("%s dut%0d stall valid", tag, d), 64'(rv[d]), 64'd1);
               chk($sformatf("%s dut%0d stall res_y", tag, d), ry[d], py[d]);
               chk($sformatf("%s dut%0d stall res_vec", tag, d), 64'(rvec[d]), 64'(pvec[d]));
               chk($sformatf("%s dut%0d stall dec_x", tag, d), 64'(dx[d]), 64'(px[d]));
            end
            if (rv[d] && res_ready) begin
               if (got_n[d] < 16) begin
                  got_r[d][got_n[d]].vec = rvec[d];
                  got_r[d][got_n[d]].y   = ry[d];
               end
               got_n[d]++;
            end
            pv[d]   = rv[d] && !res_ready;
            py[d]   = ry[d];
            pvec[d] = rvec[d];
            px[d]   = dx[d];
            if (dn[d]) begin
               done_cnt[d]++;
               if (done_t[d] < 0) done_t[d] = t;
            end
         end
      end
      start = 1'b0;
      res_ready = 1'b1;
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("%s dut%0d done pulses", tag, d), 64'(done_cnt[d]), 64'd1);
         chk($sformatf("%s dut%0d idle busy", tag, d), 64'(bz[d]), 64'd0);
         chk($sformatf("%s dut%0d idle done", tag, d), 64'(dn[d]), 64'd0);
         chk($sformatf("%s dut%0d result count", tag, d), 64'(got_n[d]), 64'(exp_n[d]));
         lim = (got_n[d] < exp_n[d]) ? got_n[d] : exp_n[d];
         if (lim > 16) lim = 16;
         for (int i = 0; i < lim; i++) begin
            chk($sformatf("%s dut%0d res%0d vec", tag, d, i), 64'(got_r[d][i].vec), 64'(exp_r[d][i].vec));
            chk($sformatf("%s dut%0d res%0d y", tag, d, i), got_r[d][i].y, exp_r[d][i].y);
         end
         chk($sformatf("%s dut%0d hit_mask", tag, d), hm[d], exp_hit[d]);
         chk($sformatf("%s dut%0d multi_hot", tag, d), 64'(mh[d]), 64'(exp_multi[d]));
         if (rmode == 0)
            chk($sformatf("%s dut%0d done cycle", tag, d), 64'(done_t[d]), 64'(exp_cyc[d]));
      end
   endtask

   task automatic apply_vec(input vec_t tv, input string tag);
      run_scan(tv.sw, tv.vec, tv.ready_mode, tv.spur, tag);
      chk($sformatf("%s A count", tag), 64'(got_n[0]), 64'(tv.exp_n));
      chk($sformatf("%s A hit_mask", tag), hm[0], tv.exp_hit);
      chk($sformatf("%s A multi_hot", tag), 64'(mh[0]), 64'(tv.exp_multi));
      chk($sformatf("%s B count", tag), 64'(got_n[1]), 64'(tv.exp_n_b));
      if (tv.exp_done >= 0)
         chk($sformatf("%s A done cycle", tag), 64'(done_t[0]), 64'(tv.exp_done));
   endtask

   task automatic load_fixed_tab();
      for (int i = 0; i < 16; i++) tab[i] = 64'd0;
      tab[0] = C_Y0;
      tab[7] = C_Y7;
   endtask

   initial begin : watchdog
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : stim
      bit found;
      int r;
      rst = 1'b1; start = 1'b0; sweep = 1'b0; vec_in = 4'd0; res_ready = 1'b1;
      load_fixed_tab();

      tbl[0] = '{1'b0, 4'd7, 0, -1, 1, C_Y7,        1'b0,  5,  1};
      tbl[1] = '{1'b1, 4'd0, 0, -1, 2, C_Y0 | C_Y7, 1'b1, 66, 16};
      tbl[2] = '{1'b1, 4'd0, 1, -1, 2, C_Y0 | C_Y7, 1'b1, -1, 16};
      tbl[3] = '{1'b1, 4'd9, 0, 20, 2, C_Y0 | C_Y7, 1'b1, 66, 16};
      tbl[4] = '{1'b0, 4'd0, 0, -1, 1, C_Y0,        1'b1,  5,  1};
      tbl[5] = '{1'b0, 4'd5, 0, -1, 0, 64'd0,       1'b0,  4,  1};

      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset("reset");
      rst = 1'b0;

      for (int k = 0; k < 6; k++) apply_vec(tbl[k], $sformatf("vec%0d", k));

      // Reset while vector 5 is being driven, then a clean sweep
      @(negedge clk);
      start = 1'b1; sweep = 1'b1; vec_in = 4'd0;
      @(posedge clk);
      found = 1'b0;
      for (int t = 0; t < 200 && !found; t++) begin
         @(negedge clk);
         start = 1'b0;
         if (dx[0] == 4'd5) found = 1'b1;
      end
      chk("midrst reached vec5", 64'(found), 64'd1);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_reset("midrst");
      rst = 1'b0;
      apply_vec(tbl[1], "post_rst");

      // Randomised decoder contents and operations
      for (int n = 0; n < 10; n++) begin
         for (int i = 0; i < 16; i++) begin
            r = $urandom_range(0, 2);
            if (r == 0)      tab[i] = 64'd0;
            else if (r == 1) tab[i] = 64'd1 << $urandom_range(0, 63);
            else             tab[i] = {32'($urandom), 32'($urandom)};
         end
         begin
            bit         sw;
            logic [3:0] v;
            sw = 1'($urandom_range(0, 1));
            v  = 4'($urandom_range(0, 15));
            run_scan(sw, v, $urandom_range(0, 2), sw ? $urandom_range(0, 30) : -1,
                     $sformatf("rand%0d", n));
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
